// File: rtl/uart_chunk_pkg.sv
// Shared framing constants, phase and state encodings for the chunk arbiter.
package uart_chunk_pkg;

   // Framing bytes
   localparam logic [7:0] ESC      = 8'h00;
   localparam logic [7:0] EOC      = 8'h01;
   localparam logic [7:0] MIN_TYPE = 8'h02;

   // Which part of the frame the next LOAD emits
   typedef enum logic [2:0] {
      PH_HDR_ESC  = 3'd0,
      PH_HDR_TYPE = 3'd1,
      PH_PAYLOAD  = 3'd2,
      PH_EOC_ESC  = 3'd3,
      PH_EOC_VAL  = 3'd4
   } phase_e;

   // Framing FSM states
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_TRIGGER = 3'd2,
      ST_GUARD   = 3'd3,
      ST_WAIT    = 3'd4
   } state_e;

   // Types 0x00 and 0x01 collide with the escape/end-of-chunk markers
   function automatic logic is_legal_type(input logic [7:0] chunk_type);
      return (chunk_type >= MIN_TYPE);
   endfunction

endpackage

// File: rtl/uart_tx_typed_chunk_arbiter_rr_arbiter.sv
// Round-robin arbiter: first requester at or after the pointer wins; the
// pointer moves just past the winner whenever the grant is consumed.
module rr_arbiter #(
   parameter int NUM_CHANNELS  = 2,
   parameter int CH_INDEX_SIZE = 1
) (
   input  logic                     CLK,
   input  logic                     RST_N,
   input  logic [NUM_CHANNELS-1:0]  req,
   input  logic                     advance,
   output logic                     grant_valid,
   output logic [NUM_CHANNELS-1:0]  grant_onehot,
   output logic [CH_INDEX_SIZE-1:0] grant_idx
);

   logic [CH_INDEX_SIZE-1:0] ptr_r;
   logic                     grant_valid_s;
   logic [NUM_CHANNELS-1:0]  grant_onehot_s;
   logic [CH_INDEX_SIZE-1:0] grant_idx_s;

   // Channel index `offset` positions after `base`, modulo the channel count
   function automatic logic [CH_INDEX_SIZE-1:0] wrap_idx(input logic [CH_INDEX_SIZE-1:0] base,
                                                          input int offset);
      return CH_INDEX_SIZE'((int'(base) + offset) % NUM_CHANNELS);
   endfunction

   // Search from the farthest offset down so the nearest requester wins last
   always_comb begin
      grant_valid_s  = 1'b0;
      grant_idx_s    = {CH_INDEX_SIZE{1'b0}};
      grant_onehot_s = {NUM_CHANNELS{1'b0}};
      for (int off = NUM_CHANNELS - 1; off >= 0; off--) begin
         grant_valid_s = grant_valid_s | req[wrap_idx(ptr_r, off)];
         grant_idx_s   = req[wrap_idx(ptr_r, off)] ? wrap_idx(ptr_r, off) : grant_idx_s;
      end
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         grant_onehot_s[c] = grant_valid_s && (grant_idx_s == CH_INDEX_SIZE'(c));
      end
   end

   // Pointer register; channel 0 has top priority out of reset
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         ptr_r <= {CH_INDEX_SIZE{1'b0}};
      end else if (advance && grant_valid_s) begin
         ptr_r <= wrap_idx(grant_idx_s, 1);
      end else begin
         ptr_r <= ptr_r;
      end
   end

   assign grant_valid  = grant_valid_s;
   assign grant_onehot = grant_onehot_s;
   assign grant_idx    = grant_idx_s;

endmodule

// File: rtl/uart_tx_typed_chunk_arbiter.sv
// Multi-channel typed chunk sender: arbitrates producers, snapshots one chunk
// and frames it as 00 TYPE <payload, 00 doubled> 00 01 towards a UART TX.
module uart_tx_typed_chunk_arbiter
   import uart_chunk_pkg::*;
#(
   parameter int NUM_CHANNELS      = 2,
   parameter int BUFFER_BYTE_SIZE  = 8,
   parameter int BUFFER_INDEX_SIZE = 8,
   parameter int CH_INDEX_SIZE     = 1
) (
   input  logic                                       CLK,
   input  logic                                       RST_N,
   input  logic [NUM_CHANNELS-1:0]                    chunk_valid,
   input  logic [NUM_CHANNELS*BUFFER_INDEX_SIZE-1:0]  chunk_byte_size,
   input  logic [NUM_CHANNELS*BUFFER_BYTE_SIZE*8-1:0] chunk_bytes,
   input  logic [NUM_CHANNELS*8-1:0]                  chunk_type,
   output logic [NUM_CHANNELS-1:0]                    chunk_accept,
   output logic [NUM_CHANNELS-1:0]                    type_error,
   output logic                                       tx_start,
   output logic [7:0]                                 tx_data,
   input  logic                                       tx_done,
   output logic                                       busy,
   output logic [CH_INDEX_SIZE-1:0]                   active_channel
);

   localparam int BB = BUFFER_BYTE_SIZE;
   localparam int IW = BUFFER_INDEX_SIZE;
   localparam logic [IW-1:0] MAX_SIZE = IW'(BUFFER_BYTE_SIZE);

   // Registered state and outputs
   state_e                   state_r,   state_nxt_s;
   phase_e                   phase_r,   phase_nxt_s;
   logic [7:0]               buf_r      [BB];
   logic [7:0]               buf_nxt_s  [BB];
   logic [7:0]               type_r,    type_nxt_s;
   logic [IW-1:0]            size_r,    size_nxt_s;
   logic [IW-1:0]            idx_r,     idx_nxt_s;
   logic                     esc_pend_r, esc_pend_nxt_s;
   logic [NUM_CHANNELS-1:0]  accept_r,  accept_nxt_s;
   logic [NUM_CHANNELS-1:0]  type_err_r, type_err_nxt_s;
   logic                     tx_start_r, tx_start_nxt_s;
   logic [7:0]               tx_data_r, tx_data_nxt_s;
   logic                     busy_r,    busy_nxt_s;
   logic [CH_INDEX_SIZE-1:0] active_ch_r, active_ch_nxt_s;

   // Arbiter and capture-path signals
   logic [NUM_CHANNELS-1:0]  req_s;
   logic                     advance_s;
   logic                     grant_valid_s;
   logic [NUM_CHANNELS-1:0]  grant_onehot_s;
   logic [CH_INDEX_SIZE-1:0] grant_idx_s;
   logic [BB*8-1:0]          sel_bytes_s;
   logic [7:0]               sel_type_s;
   logic [IW-1:0]            sel_size_s;
   logic [7:0]               cur_byte_s;
   logic [IW-1:0]            idx_inc_s;

   // A channel whose accept pulse is on the wire still holds valid this cycle;
   // mask it so a rejected chunk is not granted a second time.
   assign req_s     = chunk_valid & ~accept_r;
   assign advance_s = (state_r == ST_IDLE);
   assign idx_inc_s = idx_r + IW'(1);

   rr_arbiter #(
      .NUM_CHANNELS  (NUM_CHANNELS),
      .CH_INDEX_SIZE (CH_INDEX_SIZE)
   ) u_rr_arbiter (
      .CLK          (CLK),
      .RST_N        (RST_N),
      .req          (req_s),
      .advance      (advance_s),
      .grant_valid  (grant_valid_s),
      .grant_onehot (grant_onehot_s),
      .grant_idx    (grant_idx_s)
   );

   // Select the granted channel's slices and the payload byte at the index
   always_comb begin
      sel_bytes_s = {(BB*8){1'b0}};
      sel_type_s  = 8'h00;
      sel_size_s  = {IW{1'b0}};
      cur_byte_s  = 8'h00;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         sel_bytes_s = (grant_idx_s == CH_INDEX_SIZE'(c)) ? chunk_bytes[c*BB*8 +: BB*8] : sel_bytes_s;
         sel_type_s  = (grant_idx_s == CH_INDEX_SIZE'(c)) ? chunk_type[c*8 +: 8]        : sel_type_s;
         sel_size_s  = (grant_idx_s == CH_INDEX_SIZE'(c)) ? chunk_byte_size[c*IW +: IW] : sel_size_s;
      end
      for (int i = 0; i < BB; i++) begin
         cur_byte_s = (idx_r == IW'(i)) ? buf_r[i] : cur_byte_s;
      end
   end

   // Next-state and next-output logic of the framing FSM
   always_comb begin
      state_nxt_s     = state_r;
      phase_nxt_s     = phase_r;
      buf_nxt_s       = buf_r;
      type_nxt_s      = type_r;
      size_nxt_s      = size_r;
      idx_nxt_s       = idx_r;
      esc_pend_nxt_s  = esc_pend_r;
      accept_nxt_s    = {NUM_CHANNELS{1'b0}};
      type_err_nxt_s  = {NUM_CHANNELS{1'b0}};
      tx_start_nxt_s  = 1'b0;
      tx_data_nxt_s   = tx_data_r;
      busy_nxt_s      = busy_r;
      active_ch_nxt_s = active_ch_r;

      case (state_r)
         ST_IDLE: begin
            if (grant_valid_s) begin
               accept_nxt_s = grant_onehot_s;
               if (!is_legal_type(sel_type_s)) begin
                  type_err_nxt_s = grant_onehot_s;
                  state_nxt_s    = ST_IDLE;
               end else begin
                  for (int i = 0; i < BB; i++) begin
                     buf_nxt_s[i] = sel_bytes_s[i*8 +: 8];
                  end
                  type_nxt_s      = sel_type_s;
                  size_nxt_s      = (sel_size_s > MAX_SIZE) ? MAX_SIZE : sel_size_s;
                  idx_nxt_s       = {IW{1'b0}};
                  esc_pend_nxt_s  = 1'b0;
                  phase_nxt_s     = PH_HDR_ESC;
                  busy_nxt_s      = 1'b1;
                  active_ch_nxt_s = grant_idx_s;
                  state_nxt_s     = ST_LOAD;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end

         ST_LOAD: begin
            case (phase_r)
               PH_HDR_ESC:  tx_data_nxt_s = ESC;
               PH_HDR_TYPE: tx_data_nxt_s = type_r;
               PH_PAYLOAD:  tx_data_nxt_s = cur_byte_s;
               PH_EOC_ESC:  tx_data_nxt_s = ESC;
               PH_EOC_VAL:  tx_data_nxt_s = EOC;
               default:     tx_data_nxt_s = ESC;
            endcase
            tx_start_nxt_s = 1'b1;
            state_nxt_s    = ST_TRIGGER;
         end

         ST_TRIGGER: state_nxt_s = ST_GUARD;

         // tx_done may still show the previous idle level here
         ST_GUARD: state_nxt_s = ST_WAIT;

         ST_WAIT: begin
            if (tx_done) begin
               state_nxt_s = ST_LOAD;
               case (phase_r)
                  PH_HDR_ESC:  phase_nxt_s = PH_HDR_TYPE;
                  PH_HDR_TYPE: phase_nxt_s = (size_r == {IW{1'b0}}) ? PH_EOC_ESC : PH_PAYLOAD;
                  PH_PAYLOAD: begin
                     if (esc_pend_r) begin
                        esc_pend_nxt_s = 1'b0;
                        idx_nxt_s      = idx_inc_s;
                        phase_nxt_s    = (idx_inc_s == size_r) ? PH_EOC_ESC : PH_PAYLOAD;
                     end else if (cur_byte_s == ESC) begin
                        esc_pend_nxt_s = 1'b1;
                     end else begin
                        idx_nxt_s   = idx_inc_s;
                        phase_nxt_s = (idx_inc_s == size_r) ? PH_EOC_ESC : PH_PAYLOAD;
                     end
                  end
                  PH_EOC_ESC:  phase_nxt_s = PH_EOC_VAL;
                  PH_EOC_VAL: begin
                     busy_nxt_s  = 1'b0;
                     state_nxt_s = ST_IDLE;
                  end
                  default: begin
                     busy_nxt_s  = 1'b0;
                     state_nxt_s = ST_IDLE;
                  end
               endcase
            end else begin
               state_nxt_s = ST_WAIT;
            end
         end

         default: begin
            busy_nxt_s  = 1'b0;
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // State, snapshot buffer and output registers
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_r     <= ST_IDLE;
         phase_r     <= PH_HDR_ESC;
         for (int i = 0; i < BB; i++) begin
            buf_r[i] <= 8'h00;
         end
         type_r      <= 8'h00;
         size_r      <= {IW{1'b0}};
         idx_r       <= {IW{1'b0}};
         esc_pend_r  <= 1'b0;
         accept_r    <= {NUM_CHANNELS{1'b0}};
         type_err_r  <= {NUM_CHANNELS{1'b0}};
         tx_start_r  <= 1'b0;
         tx_data_r   <= 8'h00;
         busy_r      <= 1'b0;
         active_ch_r <= {CH_INDEX_SIZE{1'b0}};
      end else begin
         state_r     <= state_nxt_s;
         phase_r     <= phase_nxt_s;
         buf_r       <= buf_nxt_s;
         type_r      <= type_nxt_s;
         size_r      <= size_nxt_s;
         idx_r       <= idx_nxt_s;
         esc_pend_r  <= esc_pend_nxt_s;
         accept_r    <= accept_nxt_s;
         type_err_r  <= type_err_nxt_s;
         tx_start_r  <= tx_start_nxt_s;
         tx_data_r   <= tx_data_nxt_s;
         busy_r      <= busy_nxt_s;
         active_ch_r <= active_ch_nxt_s;
      end
   end

   assign chunk_accept   = accept_r;
   assign type_error     = type_err_r;
   assign tx_start       = tx_start_r;
   assign tx_data        = tx_data_r;
   assign busy           = busy_r;
   assign active_channel = active_ch_r;

endmodule
